mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for the execute stage. It accepts MULT/MULTU/DIV/DIVU requests with rs/rt operands and raises a stall request to the hazard unit while the operation is running. On completion it drives a HI/LO result with a one-cycle write-enable into the HILO register. It replaces the free-running mul/div handshake with an explicit FSM that supports cancel on flush.

## Interface
- WIDTH, 32, operand and HI/LO width
- MUL_LAT, 2, cycles spent in MUL state (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- start_i  in  1  E-stage request, qualified with op_i/a_i/b_i; held by pipeline while stalled
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a_i  in  WIDTH  rs value (dividend / multiplicand)
- b_i  in  WIDTH  rt value (divisor / multiplier)
- cancel_i  in  1  flush of the E-stage instruction; aborts the operation
- stall_o  out  1  stall request to the hazard unit
- done_o  out  1  result valid this cycle
- hilo_we_o  out  2  {hi_we, lo_we}; 2'b11 on a committed result, else 2'b00
- hi_o  out  WIDTH  product[2W-1:W] / remainder
- lo_o  out  WIDTH  product[W-1:0] / quotient
- dz_o  out  1  divide-by-zero flag, valid with done_o

## Operation
- States: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- IDLE: start_i & ~cancel_i latches op, operands and operand signs.
  - Next state is MUL for op[1]=0; DIV for op[1]=1 with b_i≠0; DONE for op[1]=1 with b_i=0.
- MUL: product register loaded with a full 2W product (signed for MULT, unsigned for MULTU). Counter runs MUL_LAT cycles, then DONE.
- DIV: restoring unsigned division on |a|,|b| (raw values for DIVU), one quotient bit per cycle, WIDTH cycles.
  - The final iteration writes sign-corrected results: quotient negated if sign(a)^sign(b); remainder takes sign(a). Then DONE.
- Divide by zero: hi_o=a_i, lo_o={WIDTH{1'b1}}, dz_o=1. No iterations are performed.
- DONE: done_o=1; hilo_we_o=2'b11 unless cancel_i; stall_o=0. Always returns to IDLE.
- start_i seen in DONE is ignored: it is the same instruction leaving E.
- cancel_i in MUL/DIV: next state IDLE, no write. In DONE it masks done_o and hilo_we_o combinationally.
- stall_o = (IDLE & start_i & ~cancel_i & op accepted) | MUL | DIV. It does not depend on cancel_i outside IDLE, which keeps the path loop-free versus the hazard flush logic.
- hi_o/lo_o/dz_o are registered and hold their last value until the next completion.

## Timing
- Request accepted at the edge ending cycle T.
- MUL: DONE in cycle T+MUL_LAT+1. DIV: DONE in cycle T+WIDTH+1. Divide by zero: DONE in cycle T+1.
- HILO is written on the edge ending the DONE cycle, so a back-to-back MFHI/MFLO sees it one cycle later through the existing HILO path.
- A new request is accepted at the earliest in the cycle after DONE (IDLE).
- Reset values: stall_o=0, done_o=0, hilo_we_o=2'b00, hi_o=0, lo_o=0, dz_o=0, counter=0, state=IDLE.
- rst asserted mid-operation aborts immediately; no write is issued.

## Configuration
- MDU_DIV_EN defined: divider, DIV state and dz_o logic are compiled in.
- MDU_DIV_EN undefined: DIV/DIVU requests are not accepted.
  - stall_o=0 for them, no state change, hilo_we_o never asserted for them.
  - dz_o is tied 0; hi_o/lo_o are driven only by multiplies.

## Structure
- Package mdu_pkg holds:
  - op encoding constants (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU)
  - state enum typedef
  - default WIDTH
- Sub-module mdu_div_step: combinational single restoring iteration (partial remainder, divisor → next remainder, quotient bit). It is instantiated once inside `ifdef MDU_DIV_EN.

## Test plan
- MULT a=0xFFFFFFFB (-5), b=3, MUL_LAT=2, start at T -> stall_o high T..T+2, done_o at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFF1, hilo_we_o=11.
- DIVU a=100, b=7 -> done_o at T+33, lo=14, hi=2, dz_o=0.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=7, b=-2 -> lo=0xFFFFFFFD, hi=1.
- DIV a=0x1234, b=0 -> done_o at T+1, hi=0x1234, lo=0xFFFFFFFF, dz_o=1.
- DIVU started, cancel_i pulsed in 10th DIV cycle -> IDLE next cycle, stall_o low, no hilo_we_o; MULTU 6×7 issued the following cycle -> lo=42, hi=0.
- rst driven low during DIV iteration 5 -> all outputs 0 asynchronously; after release a fresh DIVU 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide sequencer:
//   - MDU_WIDTH   : default operand / HI / LO width
//   - MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU : op_i encodings
//   - mdu_state_e : sequencer FSM states
// -----------------------------------------------------------------------------
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational iteration of unsigned restoring division.
// Ports:
//   i_rem [WIDTH] : current partial remainder (always < i_dvs)
//   i_bit         : next dividend bit shifted into the remainder
//   i_dvs [WIDTH] : divisor magnitude (non-zero)
//   o_rem [WIDTH] : next partial remainder
//   o_q           : quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module mdu_div_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  // Because i_rem < i_dvs, a successful subtraction always leaves a value
  // below 2^WIDTH, so the top bit of the difference is a pure borrow flag.
  assign o_q   = ~w_diff[WIDTH];
  assign o_rem = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer for the execute stage. Raises a
// stall while an operation runs and produces a one-cycle HILO write on
// completion. A flush (cancel_i) aborts a running operation without writing.
//
// Configuration macro: MDU_DIV_EN
//   defined   : restoring divider, DIV state and divide-by-zero flag built in
//   undefined : DIV/DIVU requests are ignored, dz_o tied low
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous, active-low reset
//   start_i    : E-stage request (held by the pipeline while stalled)
//   op_i       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i   : rs / rt operands
//   cancel_i   : flush of the E-stage instruction
//   stall_o    : stall request to the hazard unit
//   done_o     : result valid this cycle
//   hilo_we_o  : {hi_we, lo_we}
//   hi_o, lo_o : product high/low or remainder/quotient (registered)
//   dz_o       : divide-by-zero flag, valid with done_o
// -----------------------------------------------------------------------------
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH   = MDU_WIDTH,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [1:0]       hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

  mdu_state_e         r_state;
  mdu_state_e         w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;
  logic               w_accept;
  logic               w_last_mul;
  logic [2*WIDTH-1:0] w_ea;
  logic [2*WIDTH-1:0] w_eb;
  logic [2*WIDTH-1:0] w_prod;

`ifdef MDU_DIV_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  logic             r_dz;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sa;
  logic             r_neg_q;
  logic             w_b_zero;
  logic             w_last_div;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_quo_raw;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_accept   = start_i & ~cancel_i;
  assign w_b_zero   = (b_i == '0);
  assign w_last_div = (r_cnt == DIV_LAST);

  // Signs only matter for DIV; DIVU divides the raw values.
  assign w_sa    = ~op_i[0] & a_i[WIDTH-1];
  assign w_sb    = ~op_i[0] & b_i[WIDTH-1];
  assign w_a_mag = w_sa ? (~a_i + 1'b1) : a_i;
  assign w_b_mag = w_sb ? (~b_i + 1'b1) : b_i;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[WIDTH-1]),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_q   (w_step_q)
  );

  // The dividend register doubles as the quotient: each iteration shifts a
  // dividend bit out of the top and a quotient bit into the bottom.
  assign w_quo_raw = {r_dvd[WIDTH-2:0], w_step_q};
  assign w_quo_fix = r_neg_q ? (~w_quo_raw + 1'b1) : w_quo_raw;
  assign w_rem_fix = r_sa ? (~w_step_rem + 1'b1) : w_step_rem;

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_rem   <= '0;
      r_dvd   <= w_a_mag;
      r_dvs   <= w_b_mag;
      r_sa    <= w_sa;
      r_neg_q <= w_sa ^ w_sb;
    end else if (r_state == ST_DIV) begin
      r_rem <= w_step_rem;
      r_dvd <= w_quo_raw;
    end
  end

  assign dz_o = r_dz;
`else
  assign w_accept = start_i & ~cancel_i & ~op_i[1];
  assign dz_o     = 1'b0;
`endif

  assign w_last_mul = (r_cnt == MUL_LAST);

  // Sign- or zero-extend to 2*WIDTH; the truncated 2*WIDTH product is then
  // correct for both MULT and MULTU.
  assign w_ea   = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_eb   = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_ea * w_eb;

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_accept) begin
      r_a      <= a_i;
      r_b      <= b_i;
      r_signed <= ~op_i[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // stall_o only looks at cancel_i in IDLE so it stays loop-free against the
  // hazard unit's flush logic once an operation is in flight.
  always_comb begin
    w_next    = r_state;
    stall_o   = 1'b0;
    done_o    = 1'b0;
    hilo_we_o = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          stall_o = 1'b1;
          if (!op_i[1]) begin
            w_next = ST_MUL;
          end
`ifdef MDU_DIV_EN
          else if (w_b_zero) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_DIV;
          end
`endif
        end
      end
      ST_MUL: begin
        stall_o = 1'b1;
        if (cancel_i) begin
          w_next = ST_IDLE;
        end else if (w_last_mul) begin
          w_next = ST_DONE;
        end
      end
      ST_DIV: begin
        stall_o = 1'b1;
`ifdef MDU_DIV_EN
        if (cancel_i) begin
          w_next = ST_IDLE;
        end else if (w_last_div) begin
          w_next = ST_DONE;
        end
`else
        w_next = ST_IDLE;
`endif
      end
      ST_DONE: begin
        // start_i here is the finishing instruction still sitting in E.
        done_o    = ~cancel_i;
        hilo_we_o = {2{~cancel_i}};
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Counter and result registers; results are loaded on the transition into
  // DONE so they are stable for the whole DONE cycle and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
`ifdef MDU_DIV_EN
      r_dz  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
`ifdef MDU_DIV_EN
          if (w_accept && op_i[1] && w_b_zero) begin
            r_hi <= a_i;
            r_lo <= '1;
            r_dz <= 1'b1;
          end
`endif
        end
        ST_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_mul && !cancel_i) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
            r_dz <= 1'b0;
`endif
          end
        end
`ifdef MDU_DIV_EN
        ST_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last_div && !cancel_i) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
            r_dz <= 1'b0;
          end
        end
`endif
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdu_sequencer
// Directed self-checking bench for mdu_sequencer (WIDTH=32, MUL_LAT=2).
// Divider scenarios are built when MDU_DIV_EN is defined; otherwise the bench
// checks that DIV/DIVU requests are ignored.
// -----------------------------------------------------------------------------
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;
  logic        stall_o;
  logic        done_o;
  logic [1:0]  hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        dz_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Results captured by run_op
  int          lat;
  logic [31:0] hi_s;
  logic [31:0] lo_s;
  logic        dz_s;
  logic [1:0]  we_s;
  logic        sok;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .cancel_i  (cancel_i),
    .stall_o   (stall_o),
    .done_o    (done_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .dz_o      (dz_o)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue a request at the next falling edge (cycle T), hold start_i like the
  // pipeline does, and record the DONE cycle offset and the outputs there.
  // sok stays 1 only if stall_o is high in T..DONE-1 and low in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    lat  = -1;
    hi_s = 'x;
    lo_s = 'x;
    dz_s = 1'bx;
    we_s = 2'bxx;
    sok  = 1'b1;
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1;
    if (stall_o !== 1'b1) sok = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat  = k;
        hi_s = hi_o;
        lo_s = lo_o;
        dz_s = dz_o;
        we_s = hilo_we_o;
        if (stall_o !== 1'b0) sok = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) sok = 1'b0;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_chk++; if (hilo_we_o !== 2'b00) begin n_fail++; $display("FAIL reset_we: got %b want 00", hilo_we_o); end
    n_chk++; if (hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi_o); end
    n_chk++; if (lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo_o); end
    n_chk++; if (dz_o !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", dz_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    run_op(2'b00, 32'hFFFF_FFFB, 32'd3);
    n_chk++; if (lat !== 3) begin n_fail++; $display("FAIL mult_lat: got %0d want 3", lat); end
    n_chk++; if (sok !== 1'b1) begin n_fail++; $display("FAIL mult_stall: got %b want 1", sok); end
    n_chk++; if (hi_s !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi_s); end
    n_chk++; if (lo_s !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h want fffffff1", lo_s); end
    n_chk++; if (we_s !== 2'b11) begin n_fail++; $display("FAIL mult_we: got %b want 11", we_s); end
    n_chk++; if (dz_s !== 1'b0) begin n_fail++; $display("FAIL mult_dz: got %b want 0", dz_s); end
    @(negedge clk);
    n_chk++; if (hilo_we_o !== 2'b00) begin n_fail++; $display("FAIL mult_we_after: got %b want 00", hilo_we_o); end
    n_chk++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_hold: got %h_%h want ffffffff_fffffff1", hi_o, lo_o); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_chk++; if ({hi_s, lo_s} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi_s, lo_s); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    n_chk++; if ({hi_s, lo_s} !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL mult_minmin: got %h_%h want 40000000_00000000", hi_s, lo_s); end
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_chk++; if ({hi_s, lo_s} !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL mult_m1m1: got %h_%h want 00000000_00000001", hi_s, lo_s); end
  endtask

  task automatic test_back_to_back;
    run_op(2'b00, 32'd3, 32'd4);
    n_chk++; if (lat !== 3 || lo_s !== 32'd12 || hi_s !== 32'd0) begin n_fail++; $display("FAIL b2b_first: got lat %0d %h_%h want 3 0_c", lat, hi_s, lo_s); end
    // run_op starts in the very next cycle, i.e. the IDLE cycle after DONE.
    run_op(2'b01, 32'd6, 32'd7);
    n_chk++; if (lat !== 3 || lo_s !== 32'd42 || hi_s !== 32'd0) begin n_fail++; $display("FAIL b2b_second: got lat %0d %h_%h want 3 0_2a", lat, hi_s, lo_s); end
  endtask

  task automatic test_cancel_idle;
    @(negedge clk);
    start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b00; a_i = 32'd5; b_i = 32'd5;
    #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_stall: got %b want 0", stall_o); end
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_idle_noaccept: got stall %b want 0", stall_o); end
  endtask

  task automatic test_cancel_mul;
    // hi/lo hold 0 / 42 from the back-to-back test
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'h10; b_i = 32'h10;
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b1;
    #1;
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL cancel_mul_stall: got %b want 1", stall_o); end
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    n_chk++; if (stall_o !== 1'b0 || done_o !== 1'b0 || hilo_we_o !== 2'b00) begin n_fail++; $display("FAIL cancel_mul_idle: got stall %b done %b we %b want 0 0 00", stall_o, done_o, hilo_we_o); end
    @(negedge clk);
    n_chk++; if (done_o !== 1'b0 || hilo_we_o !== 2'b00) begin n_fail++; $display("FAIL cancel_mul_nowrite: got done %b we %b want 0 00", done_o, hilo_we_o); end
    n_chk++; if (lo_o !== 32'd42 || hi_o !== 32'd0) begin n_fail++; $display("FAIL cancel_mul_hold: got %h_%h want 0_2a", hi_o, lo_o); end
  endtask

  task automatic test_cancel_done;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd11; b_i = 32'd11;
    repeat (3) @(negedge clk);
    n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL cancel_done_reach: got done %b want 1", done_o); end
    cancel_i = 1'b1;
    #1;
    n_chk++; if (done_o !== 1'b0 || hilo_we_o !== 2'b00 || stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_done_mask: got done %b we %b stall %b want 0 00 0", done_o, hilo_we_o, stall_o); end
    @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b0;
    #1;
    n_chk++; if (done_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL cancel_done_idle: got done %b stall %b want 0 0", done_o, stall_o); end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div;
    run_op(2'b11, 32'd100, 32'd7);
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL divu_lat: got %0d want 33", lat); end
    n_chk++; if (sok !== 1'b1) begin n_fail++; $display("FAIL divu_stall: got %b want 1", sok); end
    n_chk++; if (lo_s !== 32'd14 || hi_s !== 32'd2 || dz_s !== 1'b0 || we_s !== 2'b11) begin n_fail++; $display("FAIL divu_res: got %h_%h dz %b we %b want 2_e 0 11", hi_s, lo_s, dz_s, we_s); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    n_chk++; if (lo_s !== 32'hFFFF_FFFD || hi_s !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_a: got %h_%h want ffffffff_fffffffd", hi_s, lo_s); end
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    n_chk++; if (lo_s !== 32'hFFFF_FFFD || hi_s !== 32'd1) begin n_fail++; $display("FAIL div_neg_b: got %h_%h want 00000001_fffffffd", hi_s, lo_s); end
    run_op(2'b10, 32'h1234, 32'd0);
    n_chk++; if (lat !== 1 || sok !== 1'b1) begin n_fail++; $display("FAIL dz_lat: got %0d stall_ok %b want 1 1", lat, sok); end
    n_chk++; if (hi_s !== 32'h1234 || lo_s !== 32'hFFFF_FFFF || dz_s !== 1'b1) begin n_fail++; $display("FAIL dz_res: got %h_%h dz %b want 1234_ffffffff 1", hi_s, lo_s, dz_s); end
  endtask

  task automatic test_cancel_div;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd1000; b_i = 32'd3;
    repeat (10) @(negedge clk);
    start_i = 1'b0; cancel_i = 1'b1;
    #1;
    n_chk++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL cancel_div_stall: got %b want 1", stall_o); end
    @(negedge clk);
    cancel_i = 1'b0;
    #1;
    n_chk++; if (stall_o !== 1'b0 || done_o !== 1'b0 || hilo_we_o !== 2'b00) begin n_fail++; $display("FAIL cancel_div_idle: got stall %b done %b we %b want 0 0 00", stall_o, done_o, hilo_we_o); end
    run_op(2'b01, 32'd6, 32'd7);
    n_chk++; if (lat !== 3 || lo_s !== 32'd42 || hi_s !== 32'd0) begin n_fail++; $display("FAIL cancel_div_mult: got lat %0d %h_%h want 3 0_2a", lat, hi_s, lo_s); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd77; b_i = 32'd5;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({stall_o, done_o, hilo_we_o, dz_o} !== 5'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_mid: got stall %b done %b we %b dz %b %h_%h want all 0", stall_o, done_o, hilo_we_o, dz_o, hi_o, lo_o); end
    @(negedge clk);
    rst = 1'b1;
    run_op(2'b11, 32'd9, 32'd3);
    n_chk++; if (lat !== 33 || lo_s !== 32'd3 || hi_s !== 32'd0) begin n_fail++; $display("FAIL reset_mid_divu: got lat %0d %h_%h want 33 0_3", lat, hi_s, lo_s); end
  endtask
`else
  task automatic test_div_disabled;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd0;
    #1;
    n_chk++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL nodiv_stall: got %b want 0", stall_o); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op_i = (k < 2) ? 2'b10 : 2'b11;
      b_i  = 32'd7;
      #1;
      n_chk++; if (stall_o !== 1'b0 || done_o !== 1'b0 || hilo_we_o !== 2'b00 || dz_o !== 1'b0) begin n_fail++; $display("FAIL nodiv_cycle%0d: got stall %b done %b we %b dz %b want 0 0 00 0", k, stall_o, done_o, hilo_we_o, dz_o); end
    end
    start_i = 1'b0;
    run_op(2'b01, 32'd2, 32'd3);
    n_chk++; if (lat !== 3 || lo_s !== 32'd6 || hi_s !== 32'd0) begin n_fail++; $display("FAIL nodiv_then_mult: got lat %0d %h_%h want 3 0_6", lat, hi_s, lo_s); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd77; b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({stall_o, done_o, hilo_we_o, dz_o} !== 5'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_mid: got stall %b done %b we %b dz %b %h_%h want all 0", stall_o, done_o, hilo_we_o, dz_o, hi_o, lo_o); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid_nodone: got %b want 0", done_o); end
    end
    run_op(2'b01, 32'd9, 32'd3);
    n_chk++; if (lat !== 3 || lo_s !== 32'd27 || hi_s !== 32'd0) begin n_fail++; $display("FAIL reset_mid_mult: got lat %0d %h_%h want 3 0_1b", lat, hi_s, lo_s); end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_cancel_idle();
    test_cancel_mul();
    test_cancel_done();
`ifdef MDU_DIV_EN
    test_div();
    test_cancel_div();
`else
    test_div_disabled();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
